// File: rtl/uart_pkg.sv
// Shared widths for the UART receive path plus the saturating increment
// used by the error counter.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned ERR_CNT_W   = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer: queues bytes from the UART receiver onto a valid/ready
// stream and keeps sticky overrun/framing flags and a saturating error counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_err,
    output logic [UART_DATA_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ADDR_W:0]        count,
    output logic                   overrun,
    output logic                   frame_err,
    output logic [ERR_CNT_W-1:0]   err_count,
    input  logic                   clear_flags
);

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic overflow;
    logic rx_err_q;
    logic err_event;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (rx_data),
        .rd_data (m_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign m_valid   = !empty;
    assign pop       = !empty && m_ready;
    assign push      = rx_valid && (!full || pop);
    assign overflow  = rx_valid && full && !pop;
    assign err_event = rx_err && !rx_err_q;

    // Set/increment takes priority over clear_flags in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_err_q  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            rx_err_q <= rx_err;

            if (overflow) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end

            if (err_event) begin
                frame_err <= 1'b1;
                err_count <= clear_flags ? ERR_CNT_W'(1) : sat_inc(err_count);
            end else if (clear_flags) begin
                frame_err <= 1'b0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios followed by a random phase,
// all checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic       overrun;
    logic       frame_err;
    logic [7:0] err_count;
    logic       clear_flags;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .count       (count),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q[$];
    bit         ov_m;
    bit         fe_m;
    int         ec_m;
    bit         err_prev;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(count),     32'(q.size()));
        check({tag, ".m_valid"},   32'(m_valid),   32'(q.size() > 0));
        if (q.size() > 0) check({tag, ".m_data"}, 32'(m_data), 32'(q[0]));
        check({tag, ".overrun"},   32'(overrun),   32'(ov_m));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(fe_m));
        check({tag, ".err_count"}, 32'(err_count), 32'(ec_m));
    endtask

    task automatic model_reset();
        q.delete();
        ov_m     = 0;
        fe_m     = 0;
        ec_m     = 0;
        err_prev = 0;
    endtask

    // Applies the current inputs to the model, clocks once, then checks.
    task automatic tick(input string tag);
        int  n;
        bit  pop_m;
        bit  push_m;
        n      = q.size();
        pop_m  = (n > 0) && m_ready;
        push_m = rx_valid && (n < DEPTH || pop_m);
        if (clear_flags) begin
            ov_m = 0;
            fe_m = 0;
            ec_m = 0;
        end
        if (rx_valid && !push_m) ov_m = 1;
        if (rx_err && !err_prev) begin
            fe_m = 1;
            ec_m = (ec_m >= 255) ? 255 : ec_m + 1;
        end
        err_prev = rx_err;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(rx_data);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic push_byte(input logic [7:0] b, input string tag);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(tag);
        rx_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        rx_err      = 1'b0;
        m_ready     = 1'b0;
        clear_flags = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;
        tick("idle");

        // 1: three pushes, then drain in order
        push_byte(8'h55, "t1.push0");
        push_byte(8'hA3, "t1.push1");
        push_byte(8'h0F, "t1.push2");
        check("t1.count3", 32'(count), 32'd3);
        check("t1.head55", 32'(m_data), 32'h55);
        m_ready = 1'b1;
        tick("t1.pop0");
        check("t1.headA3", 32'(m_data), 32'hA3);
        tick("t1.pop1");
        check("t1.head0F", 32'(m_data), 32'h0F);
        tick("t1.pop2");
        check("t1.empty", 32'(m_valid), 32'd0);
        m_ready = 1'b0;

        // 2: overflow with 17 pushes, 0x10 is lost
        for (int i = 0; i < 17; i++) push_byte(8'(i), "t2.push");
        check("t2.count16", 32'(count), 32'd16);
        check("t2.overrun", 32'(overrun), 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2.seq", 32'(m_data), 32'(i));
            tick("t2.pop");
        end
        check("t2.drained", 32'(m_valid), 32'd0);
        m_ready = 1'b0;

        // 3: full FIFO, push and pop together
        clear_flags = 1'b1;
        tick("t3.clear");
        clear_flags = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), "t3.fill");
        m_ready = 1'b1;
        push_byte(8'h77, "t3.pushpop");
        check("t3.no_overrun", 32'(overrun), 32'd0);
        check("t3.count16", 32'(count), 32'd16);
        for (int i = 0; i < 15; i++) tick("t3.drain");
        check("t3.last77", 32'(m_data), 32'h77);
        tick("t3.drain_last");
        m_ready = 1'b0;

        // 4: held level counts once, then two pulses; clear coincides with a rise
        rx_err = 1'b1;
        repeat (40) tick("t4.hold");
        rx_err = 1'b0;
        tick("t4.low");
        for (int i = 0; i < 2; i++) begin
            rx_err = 1'b1; tick("t4.pulse_hi");
            rx_err = 1'b0; tick("t4.pulse_lo");
        end
        check("t4.err3", 32'(err_count), 32'd3);
        check("t4.fe", 32'(frame_err), 32'd1);
        rx_err      = 1'b1;
        clear_flags = 1'b1;
        tick("t4.clear_rise");
        clear_flags = 1'b0;
        rx_err      = 1'b0;
        check("t4.err1", 32'(err_count), 32'd1);
        check("t4.fe_kept", 32'(frame_err), 32'd1);
        tick("t4.settle");

        // 5: saturation after 260 more edges
        for (int i = 0; i < 260; i++) begin
            rx_err = 1'b1; tick("t5.hi");
            rx_err = 1'b0; tick("t5.lo");
        end
        check("t5.sat", 32'(err_count), 32'd255);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), "t6.fill");
        check("t6.count5", 32'(count), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        push_byte(8'h3C, "t6.push3C");
        check("t6.head3C", 32'(m_data), 32'h3C);
        check("t6.valid", 32'(m_valid), 32'd1);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            rx_valid    = ($urandom_range(0, 99) < 60);
            rx_data     = 8'($urandom);
            m_ready     = ($urandom_range(0, 99) < 45);
            rx_err      = ($urandom_range(0, 99) < 20);
            clear_flags = ($urandom_range(0, 99) < 5);
            tick("rand");
        end
        rx_valid    = 1'b0;
        clear_flags = 1'b0;
        rx_err      = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Buffers bytes from the UART receiver in a first-word-fall-through FIFO and presents them to the system on a valid/ready stream.
- Sits directly downstream of the receiver: consumes its one-cycle `valid` pulse, its 8-bit `out` byte and its `err` level.
- Tracks receive errors with sticky overrun and framing flags and a saturating framing-error counter.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `ADDR_W`, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte from the receiver.
- `rx_valid` in 1: one-cycle pulse; `rx_data` is valid this cycle.
- `rx_err` in 1: receiver error level; may stay high for many cycles.
- `m_data` out 8: head-of-FIFO byte.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts `m_data` when high with `m_valid`.
- `count` out ADDR_W+1: number of stored bytes, 0..DEPTH.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `frame_err` out 1: sticky; at least one receiver error occurred.
- `err_count` out 8: count of receiver error events, saturates at 255.
- `clear_flags` in 1: synchronous clear of `overrun`, `frame_err` and `err_count`.

## Operation
- **Push.** When `rx_valid` is high and (`count` < DEPTH, or a pop happens in the same cycle), `rx_data` is written at `wr_ptr` and `wr_ptr` increments.
- **Overflow.** When `rx_valid` is high, `count` == DEPTH and there is no pop in the same cycle:
  - the byte is dropped;
  - `overrun` is set;
  - FIFO contents and pointers are unchanged.
- **Pop.** Occurs when `m_valid && m_ready`; `rd_ptr` increments. `m_ready` while empty has no effect.
- **Simultaneous push and pop.** Both occur and `count` is unchanged. At `count` == 0, only the push occurs because `m_valid` is low.
- **Pointer arithmetic.**
  - Pointers are ADDR_W+1 bits and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the lower ADDR_W bits are equal.
  - `count` = `wr_ptr` − `rd_ptr`, modulo 2^(ADDR_W+1).
- **Error event.** A rising edge of `rx_err`, detected against a registered copy `rx_err_q`, is one event.
  - Each event sets `frame_err` and increments `err_count`, saturating at 255.
  - A level held high counts once.
  - `rx_data` is not written on an error event.
- **`clear_flags`.**
  - Clears `overrun`, `frame_err` and `err_count` to 0.
  - If an error event or overflow occurs in the same cycle, the set/increment wins: the flag ends at 1 and the counter ends at 1.
  - Does not affect FIFO contents.
- **Reset, including mid-operation.** While `reset_n` is low:
  - pointers = 0, `rx_err_q` = 0;
  - `m_valid` = 0, `count` = 0, `overrun` = 0, `frame_err` = 0, `err_count` = 0;
  - memory contents are not reset; `m_data` is don't-care while `m_valid` = 0.
- **State machine.** None beyond the pointer state: EMPTY (`count` = 0), PARTIAL, FULL (`count` = DEPTH), derived from the pointers.

## Timing
- Push at cycle N: `count` increments and `m_valid` rises at N+1; `m_data` equals the byte at N+1 if the FIFO was empty.
- Pop at cycle N: the next byte appears on `m_data` at N+1.
- `m_data` is a combinational read of `mem[rd_ptr]` from registered memory. No bypass path: a push into an empty FIFO is never visible in the same cycle.
- `rx_err` rising at cycle N: `frame_err` is 1 and `err_count` has incremented at N+1.
- Overflow at cycle N: `overrun` is 1 at N+1.
- All outputs are registered or derived from registers. Throughput is one push and one pop per cycle.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W` = 8 and `ERR_CNT_W` = 8.
- Sub-module `sync_fifo` (params WIDTH, DEPTH) holds the storage, pointers, full/empty and count.
- `uart_rx_fifo` wraps `sync_fifo` and adds:
  - the push qualification;
  - overrun detection;
  - the `rx_err` edge detector;
  - the flags and error counter.

## Test plan
1. Reset, then push 0x55, 0xA3, 0x0F on separate `rx_valid` pulses with `m_ready` = 0 → `count` = 3, `m_data` = 0x55. Then `m_ready` = 1 for 3 cycles → outputs 0x55, 0xA3, 0x0F in order, then `m_valid` = 0.
2. DEPTH = 16: push 17 bytes 0x00..0x10 with no pops → `count` = 16, `overrun` = 1, and the pop sequence is 0x00..0x0F (0x10 lost).
3. FIFO full with `m_ready` = 1 and a push of 0x77 in the same cycle → no overrun, `count` stays 16, and 0x77 emerges last.
4. Hold `rx_err` high 40 cycles, drop it, then pulse it twice → `err_count` = 3, `frame_err` = 1. Then assert `clear_flags` in a cycle coinciding with a new `rx_err` rise → `err_count` = 1, `frame_err` = 1.
5. Fill with 256+ error edges → `err_count` saturates at 255.
6. Assert `reset_n` low mid-stream with `count` = 5 → `m_valid`, `count`, flags and `err_count` all 0 asynchronously. After release, a new push of 0x3C → `m_data` = 0x3C one cycle later.
